// File: rtl/mrc_std_bridge_pkg.sv
// Shared types for the MRC -> STD lane bridge: framing codes, framing FSM states
// and default sizing.
package mrc_std_bridge_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 16;

  typedef enum logic [1:0] {
    CNTL_SOD_EOD = 2'b00,
    CNTL_SOD     = 2'b01,
    CNTL_MOD     = 2'b10,
    CNTL_EOD     = 2'b11
  } cntl_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_IN_OP = 1'b1
  } state_e;

endpackage

// File: rtl/generic_fwft_fifo.sv
// First-word fall-through FIFO with extended-pointer full/empty detection.
// A push into a full FIFO is ignored even if a pop happens in the same cycle.
module generic_fwft_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage is data only; it carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/mrc_std_lane_bridge.sv
// Per-lane elastic bridge from MRC output to STD lane input with framing check.
// Optional macro MRC_STD_LANE_BRIDGE_PARITY_EN adds per-entry even parity.
module mrc_std_lane_bridge
  import mrc_std_bridge_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_poweron,
  input  logic              mrc__std__valid,
  input  logic [1:0]        mrc__std__cntl,
  input  logic [DATA_W-1:0] mrc__std__data,
  output logic              std__mrc__ready,
  output logic              std__lane__valid,
  output logic [1:0]        std__lane__cntl,
  output logic [DATA_W-1:0] std__lane__data,
  input  logic              std__lane__ready,
  output logic [CNT_W-1:0]  operand_count,
  output logic              framing_error,
`ifdef MRC_STD_LANE_BRIDGE_PARITY_EN
  output logic              std__lane__parity,
`endif
  output logic              bridge_idle
);

`ifdef MRC_STD_LANE_BRIDGE_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int FW = 2 + DATA_W + PAR_W;
  localparam int AW = $clog2(DEPTH);

  function automatic logic even_parity(input logic [DATA_W+1:0] v);
    return ^v;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             push_word, complete, violation, par_err;
  logic             in_xfer, out_xfer;
  logic [FW-1:0]    fifo_din, fifo_dout;
  logic [AW:0]      fifo_count;
  logic             fifo_full, fifo_empty;

  assign in_xfer  = mrc__std__valid & std__mrc__ready;
  assign out_xfer = std__lane__valid & std__lane__ready;

  // Framing decision for the word on the input this cycle.
  always_comb begin
    push_word = 1'b0;
    complete  = 1'b0;
    violation = 1'b0;
    state_d   = state_q;
    if (in_xfer) begin
      case (state_q)
        ST_IDLE: begin
          case (cntl_e'(mrc__std__cntl))
            CNTL_SOD:     begin push_word = 1'b1; state_d = ST_IN_OP; end
            CNTL_SOD_EOD: begin push_word = 1'b1; complete = 1'b1; end
            default:      violation = 1'b1;
          endcase
        end
        default: begin
          case (cntl_e'(mrc__std__cntl))
            CNTL_MOD: push_word = 1'b1;
            CNTL_EOD: begin push_word = 1'b1; complete = 1'b1; state_d = ST_IDLE; end
            default:  violation = 1'b1;
          endcase
        end
      endcase
    end
  end

`ifdef MRC_STD_LANE_BRIDGE_PARITY_EN
  assign fifo_din          = {even_parity({mrc__std__cntl, mrc__std__data}),
                              mrc__std__cntl, mrc__std__data};
  assign std__lane__parity = fifo_dout[FW-1];
  assign par_err           = out_xfer &
                             (fifo_dout[FW-1] != even_parity(fifo_dout[DATA_W+1:0]));
`else
  assign fifo_din = {mrc__std__cntl, mrc__std__data};
  assign par_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (complete)             cnt_q <= cnt_q + CNT_W'(1);
      if (violation | par_err)  err_q <= 1'b1;
    end
  end

  generic_fwft_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset_poweron),
    .push_i  (push_word),
    .pop_i   (out_xfer),
    .din_i   (fifo_din),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // All handshake outputs come from registered state only.
  assign std__mrc__ready  = ~fifo_full;
  assign std__lane__valid = (fifo_count != '0);
  assign std__lane__cntl  = fifo_dout[DATA_W+1:DATA_W];
  assign std__lane__data  = fifo_dout[DATA_W-1:0];
  assign operand_count    = cnt_q;
  assign framing_error    = err_q;
  assign bridge_idle      = fifo_empty & (state_q == ST_IDLE);

endmodule

// File: tb/tb_mrc_std_lane_bridge.sv
// Bench for mrc_std_lane_bridge: framing-rule scoreboard checked every cycle plus
// directed literal checks.
module tb_mrc_std_lane_bridge;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              reset_poweron;
  logic              mrc__std__valid;
  logic [1:0]        mrc__std__cntl;
  logic [DATA_W-1:0] mrc__std__data;
  logic              std__mrc__ready;
  logic              std__lane__valid;
  logic [1:0]        std__lane__cntl;
  logic [DATA_W-1:0] std__lane__data;
  logic              std__lane__ready;
  logic [CNT_W-1:0]  operand_count;
  logic              framing_error;
  logic              bridge_idle;
`ifdef MRC_STD_LANE_BRIDGE_PARITY_EN
  logic              std__lane__parity;
`endif

  mrc_std_lane_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset_poweron    (reset_poweron),
    .mrc__std__valid  (mrc__std__valid),
    .mrc__std__cntl   (mrc__std__cntl),
    .mrc__std__data   (mrc__std__data),
    .std__mrc__ready  (std__mrc__ready),
    .std__lane__valid (std__lane__valid),
    .std__lane__cntl  (std__lane__cntl),
    .std__lane__data  (std__lane__data),
    .std__lane__ready (std__lane__ready),
    .operand_count    (operand_count),
    .framing_error    (framing_error),
`ifdef MRC_STD_LANE_BRIDGE_PARITY_EN
    .std__lane__parity(std__lane__parity),
`endif
    .bridge_idle      (bridge_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 0;
  bit rnd_en = 0;

  // Reference model: queue of {cntl,data}, an "inside operand" flag, counters.
  logic [33:0]      q[$];
  bit               m_in_op;
  logic [CNT_W-1:0] m_cnt;
  bit               m_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    else n_pass++;
  endtask

  always @(posedge clk) begin
    if (reset_poweron) begin
      q.delete();
      m_in_op = 0;
      m_cnt   = '0;
      m_err   = 0;
    end else begin
      bit room, pop;
      room = (q.size() != DEPTH);
      pop  = (q.size() != 0) && std__lane__ready;
      if (pop) void'(q.pop_front());
      if (mrc__std__valid && room) begin
        case (mrc__std__cntl)
          2'b01: if (m_in_op) m_err = 1;
                 else begin q.push_back({mrc__std__cntl, mrc__std__data}); m_in_op = 1; end
          2'b00: if (m_in_op) m_err = 1;
                 else begin q.push_back({mrc__std__cntl, mrc__std__data}); m_cnt++; end
          2'b10: if (!m_in_op) m_err = 1;
                 else q.push_back({mrc__std__cntl, mrc__std__data});
          default: if (!m_in_op) m_err = 1;
                   else begin q.push_back({mrc__std__cntl, mrc__std__data}); m_cnt++; m_in_op = 0; end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("lane_valid", std__lane__valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("lane_cntl", std__lane__cntl, q[0][33:32]);
        chk("lane_data", std__lane__data, q[0][31:0]);
      end
      chk("mrc_ready", std__mrc__ready, q.size() != DEPTH);
      chk("operand_count", operand_count, m_cnt);
      chk("framing_error", framing_error, m_err);
      chk("bridge_idle", bridge_idle, (q.size() == 0) && !m_in_op);
    end
  end

  task automatic tick();
    @(negedge clk);
    if (rnd_en) std__lane__ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [1:0] c, input logic [31:0] d);
    int t = 0;
    mrc__std__valid = 1'b1;
    mrc__std__cntl  = c;
    mrc__std__data  = d;
    while (!std__mrc__ready && t < 1000) begin tick(); t++; end
    if (t >= 1000) chk("send_timeout", 1, 0);
    tick();
    mrc__std__valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (std__lane__valid && t < 2000) begin tick(); t++; end
    chk("drain_bound", t < 2000, 1);
  endtask

  task automatic do_reset();
    reset_poweron = 1'b1;
    tick();
    reset_poweron = 1'b0;
  endtask

  initial begin
    reset_poweron    = 1'b1;
    mrc__std__valid  = 1'b0;
    mrc__std__cntl   = 2'b00;
    mrc__std__data   = '0;
    std__lane__ready = 1'b1;
    tick();
    tick();
    cmp_en = 1;
    chk("rst_ready", std__mrc__ready, 1);
    chk("rst_valid", std__lane__valid, 0);
    chk("rst_idle", bridge_idle, 1);
    chk("rst_count", operand_count, 0);
    chk("rst_err", framing_error, 0);
    reset_poweron = 1'b0;

    // Single-word operand, one cycle to valid, then idle again.
    send(2'b00, 32'hDEADBEEF);
    chk("t1_valid", std__lane__valid, 1);
    chk("t1_cntl", std__lane__cntl, 2'b00);
    chk("t1_data", std__lane__data, 32'hDEADBEEF);
    chk("t1_count", operand_count, 1);
    tick();
    chk("t1_idle", bridge_idle, 1);

    // 16-word operand fills the FIFO while the lane stalls.
    do_reset();
    std__lane__ready = 1'b0;
    send(2'b01, 32'h1000);
    for (int i = 0; i < 14; i++) send(2'b10, 32'h2000 + i);
    send(2'b11, 32'h3000);
    chk("t2_ready_full", std__mrc__ready, 0);
    chk("t2_fifo_cnt", dut.fifo_count, 16);
    chk("t2_head_cntl", std__lane__cntl, 2'b01);
    std__lane__ready = 1'b1;
    drain();
    chk("t2_count", operand_count, 1);

    // Framing violations.
    do_reset();
    send(2'b11, 32'hBAD0);
    chk("t3_err", framing_error, 1);
    chk("t3_valid", std__lane__valid, 0);
    std__lane__ready = 1'b0;
    send(2'b01, 32'hA1);
    send(2'b10, 32'hA2);
    send(2'b01, 32'hA3);
    send(2'b11, 32'hA4);
    chk("t3_fifo_cnt", dut.fifo_count, 3);
    chk("t3_count", operand_count, 1);
    std__lane__ready = 1'b1;
    drain();

    // Random-length stream against a randomly stalling consumer.
    do_reset();
    rnd_en = 1;
    for (int op = 0; op < 1000; op++) begin
      int len = $urandom_range(1, 20);
      if (len == 1) send(2'b00, $urandom);
      else begin
        send(2'b01, $urandom);
        for (int k = 1; k < len - 1; k++) send(2'b10, $urandom);
        send(2'b11, $urandom);
      end
    end
    rnd_en = 0;
    std__lane__ready = 1'b1;
    drain();
    chk("t4_count", operand_count, 1000);
    chk("t4_err", framing_error, 0);

    // Reset in the middle of a buffered operand.
    do_reset();
    std__lane__ready = 1'b0;
    send(2'b01, 32'h50);
    for (int i = 0; i < 4; i++) send(2'b10, 32'h51 + i);
    chk("t5_fifo_cnt", dut.fifo_count, 5);
    reset_poweron = 1'b1;
    tick();
    chk("t5_valid", std__lane__valid, 0);
    chk("t5_fifo_zero", dut.fifo_count, 0);
    chk("t5_idle", bridge_idle, 1);
    chk("t5_count", operand_count, 0);
    reset_poweron = 1'b0;
    send(2'b01, 32'h1234);
    chk("t5_new_valid", std__lane__valid, 1);
    chk("t5_new_cntl", std__lane__cntl, 2'b01);
    chk("t5_new_data", std__lane__data, 32'h1234);
    std__lane__ready = 1'b1;
    send(2'b11, 32'h1235);
    drain();
    chk("t5_end_count", operand_count, 1);

`ifdef MRC_STD_LANE_BRIDGE_PARITY_EN
    do_reset();
    std__lane__ready = 1'b0;
    send(2'b00, 32'h000000A5);
    cmp_en = 0;
    dut.u_fifo.mem_q[0] = dut.u_fifo.mem_q[0] ^ 35'd1;
    chk("par_pre_err", framing_error, 0);
    std__lane__ready = 1'b1;
    tick();
    chk("par_err", framing_error, 1);
    do_reset();
    cmp_en = 1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
